instr_fetch_unit: RTL

//  Instruction-fetch stage of the RISC-V core. Holds the PC and drives the

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC register, combinational ROM addressing and the
// IF/ID pipeline register with valid/ready handshake, redirect and end-of-ROM halt.
//
// state | meaning
// RUN   | fetching sequentially from pc while it lies inside ROM space
// HALT  | pc ran past the ROM; idle until a branch redirect or reset
module instr_fetch_unit #(
  parameter int              PC_WIDTH       = 32,
  parameter int              ROM_ADDR_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]     NOP_INSTR      = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ROM_ADDR_WIDTH-1:0] rom_endereco,
  input  logic [31:0]               rom_saida,
  input  logic                      branch_taken,
  input  logic [PC_WIDTH-1:0]       branch_target,
  input  logic                      id_ready,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [PC_WIDTH-1:0]       if_pc,
  output logic                      halted,
  output logic                      misalign_err,
  output logic [15:0]               fetch_count
);

  localparam int unsigned ROM_BYTES = 2 ** ROM_ADDR_WIDTH;

  typedef enum logic {RUN, HALT} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] if_pc_nxt;
  logic [31:0]         if_instr_nxt;
  logic                if_valid_nxt;
  logic                misalign_nxt;
  logic [15:0]         fetch_count_nxt;
  logic                can_load;
  logic                in_rom;

  assign rom_endereco = pc[ROM_ADDR_WIDTH-1:0];
  assign halted       = (state == HALT);
  assign can_load     = !if_valid || id_ready;
  // Full-width compare so a PC with any upper bit set counts as outside ROM.
  assign in_rom       = (pc < PC_WIDTH'(ROM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      if_valid     <= if_valid_nxt;
      if_instr     <= if_instr_nxt;
      if_pc        <= if_pc_nxt;
      misalign_err <= misalign_nxt;
      fetch_count  <= fetch_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_valid_nxt    = if_valid;
    if_instr_nxt    = if_instr;
    if_pc_nxt       = if_pc;
    misalign_nxt    = misalign_err;
    fetch_count_nxt = fetch_count;

    if (branch_taken) begin
      // Redirect flushes IF/ID regardless of stall or concurrent consume.
      pc_nxt       = {branch_target[PC_WIDTH-1:2], 2'b00};
      if_valid_nxt = 1'b0;
      if_instr_nxt = NOP_INSTR;
      state_nxt    = RUN;
      if (branch_target[1:0] != 2'b00) begin
        misalign_nxt = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (can_load) begin
            if (in_rom) begin
              if_instr_nxt = rom_saida;
              if_pc_nxt    = pc;
              if_valid_nxt = 1'b1;
              pc_nxt       = pc + PC_WIDTH'(4);
              if (fetch_count != 16'hFFFF) begin
                fetch_count_nxt = fetch_count + 16'd1;
              end
            end else begin
              state_nxt    = HALT;
              if_valid_nxt = 1'b0;
              if_instr_nxt = NOP_INSTR;
            end
          end
        end
        HALT: begin
          if (id_ready) begin
            if_valid_nxt = 1'b0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule
